// File: rtl/d_grf_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and scoreboard.
package d_grf_scoreboard_pkg;

    // Address width for a register file of n entries (minimum 1 bit)
    function automatic int unsigned grf_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Architectural zero register
    localparam int unsigned REG_ZERO = 0;

    // Scoreboard error kinds reported by the trace
    typedef enum logic {
        ERR_OVF = 1'b0,
        ERR_UNF = 1'b1
    } err_kind_e;

endpackage

// File: rtl/d_fwd_select.sv
// One read port: priority forwarding mux with write-through and a hit flag.
module d_fwd_select
    import d_grf_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned FWD_N  = 3
) (
    input  logic [AW-1:0]           rd_addr_i,
    input  logic [FWD_N-1:0]        fwd_valid_i,
    input  logic [FWD_N*AW-1:0]     fwd_addr_i,
    input  logic [FWD_N*DATA_W-1:0] fwd_data_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic [DATA_W-1:0]       reg_data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    hit_o
);

    // Lowest-index forwarding source wins, then write-through, then the array
    always_comb begin
        data_o = reg_data_i;
        hit_o  = 1'b0;
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            data_o = wr_data_i;
            hit_o  = 1'b1;
        end
        for (int k = int'(FWD_N) - 1; k >= 0; k--) begin
            if (fwd_valid_i[k] && (fwd_addr_i[k*AW +: AW] == rd_addr_i)) begin
                data_o = fwd_data_i[k*DATA_W +: DATA_W];
                hit_o  = 1'b1;
            end
        end
        if (rd_addr_i == AW'(REG_ZERO)) begin
            data_o = '0;
            hit_o  = 1'b0;
        end
    end

endmodule

// File: rtl/d_grf_scoreboard.sv
// Decode-stage register file with forwarding and a pending-write scoreboard.
// Optional simulation trace of writes and errors: define GRF_TRACE_EN.
module d_grf_scoreboard
    import d_grf_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned FWD_N  = 3,
    parameter int unsigned CNT_W  = 2,
    localparam int unsigned AW    = grf_clog2(NREG)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NRD*AW-1:0]       rd_addr_i,
    output logic [NRD*DATA_W-1:0]   rd_data_o,
    output logic [NRD-1:0]          rd_stall_o,
    output logic                    stall_o,
    input  logic [NRD-1:0]          rd_use_i,
    input  logic [FWD_N-1:0]        fwd_valid_i,
    input  logic [FWD_N*AW-1:0]     fwd_addr_i,
    input  logic [FWD_N*DATA_W-1:0] fwd_data_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic [31:0]             wr_pc_i,
    input  logic                    issue_en_i,
    input  logic [AW-1:0]           issue_addr_i,
    input  logic                    kill_en_i,
    input  logic [AW-1:0]           kill_addr_i,
    output logic                    issue_ok_o,
    output logic                    err_o
);

    localparam int unsigned     CW1     = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  pend_q [NREG];
    logic [NREG-1:0]   ovf_c;
    logic [NREG-1:0]   unf_c;
    logic [NRD-1:0]    hit_c;
    logic              err_q;
    logic              err_d;

    // Read ports: forwarding select plus pending check
    for (genvar i = 0; i < int'(NRD); i++) begin : gen_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr_i[i*AW +: AW];

        d_fwd_select #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .FWD_N  (FWD_N)
        ) u_fwd (
            .rd_addr_i   (addr),
            .fwd_valid_i (fwd_valid_i),
            .fwd_addr_i  (fwd_addr_i),
            .fwd_data_i  (fwd_data_i),
            .wr_en_i     (wr_en_i),
            .wr_addr_i   (wr_addr_i),
            .wr_data_i   (wr_data_i),
            .reg_data_i  (regs_q[addr]),
            .data_o      (rd_data_o[i*DATA_W +: DATA_W]),
            .hit_o       (hit_c[i])
        );

        assign rd_stall_o[i] = (addr != AW'(REG_ZERO)) && (pend_q[addr] != '0) && !hit_c[i];
    end

    assign stall_o    = |(rd_stall_o & rd_use_i);
    assign issue_ok_o = (issue_addr_i == AW'(REG_ZERO)) || (pend_q[issue_addr_i] != CNT_MAX);

    // Per-register data and saturating pending counter; register 0 never changes
    for (genvar r = 0; r < int'(NREG); r++) begin : gen_reg
        localparam bit LIVE = (r != int'(REG_ZERO));
        logic             inc;
        logic             wr_hit;
        logic             kill_hit;
        logic [CW1-1:0]   sum;
        logic [CW1-1:0]   dec;
        logic [CW1-1:0]   net;
        logic [CNT_W-1:0] pend_d;

        assign inc      = LIVE && issue_en_i && (issue_addr_i == AW'(r)) && !stall_o;
        assign wr_hit   = LIVE && wr_en_i && (wr_addr_i == AW'(r));
        assign kill_hit = LIVE && kill_en_i && (kill_addr_i == AW'(r));
        assign sum      = CW1'(pend_q[r]) + CW1'(inc);
        assign dec      = CW1'(wr_hit) + CW1'(kill_hit);
        assign net      = sum - dec;
        assign unf_c[r] = (dec > sum);
        assign ovf_c[r] = !unf_c[r] && (net > CW1'(CNT_MAX));
        assign pend_d   = unf_c[r] ? '0 : (ovf_c[r] ? CNT_MAX : CNT_W'(net));

        // Register write and counter update
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end else begin
                if (wr_hit) regs_q[r] <= wr_data_i;
                pend_q[r] <= pend_d;
            end
        end
    end

    assign err_d = err_q | (|ovf_c) | (|unf_c);

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;

`ifdef GRF_TRACE_EN
    // Simulation-only trace of accepted writes and the first error event
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (wr_en_i && (wr_addr_i != AW'(REG_ZERO)))
                $display("[%0t] @%h: $%0d <= %h", $time, wr_pc_i, wr_addr_i, wr_data_i);
            if (err_d && !err_q) begin
                for (int r = 0; r < int'(NREG); r++) begin
                    if (ovf_c[r])
                        $display("[%0t] grf error %s on $%0d", $time,
                                 (ERR_OVF == ERR_OVF) ? "overflow" : "underflow", r);
                    else if (unf_c[r])
                        $display("[%0t] grf error %s on $%0d", $time,
                                 (ERR_UNF == ERR_OVF) ? "overflow" : "underflow", r);
                end
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^wr_pc_i;
`endif

endmodule

// File: tb/tb_d_grf_scoreboard.sv
// Self-checking bench for d_grf_scoreboard with a behavioural reference model.
module tb_d_grf_scoreboard;

    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int AWB  = 5;
    localparam int MAXP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [9:0]    rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_stall;
    logic          stall;
    logic [1:0]    rd_use;
    logic [2:0]    fwd_valid;
    logic [14:0]   fwd_addr;
    logic [95:0]   fwd_data;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   wr_pc;
    logic          issue_en;
    logic [4:0]    issue_addr;
    logic          kill_en;
    logic [4:0]    kill_addr;
    logic          issue_ok;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_reg [NR];
    int            m_pend [NR];
    bit            m_err;

    d_grf_scoreboard dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_stall_o   (rd_stall),
        .stall_o      (stall),
        .rd_use_i     (rd_use),
        .fwd_valid_i  (fwd_valid),
        .fwd_addr_i   (fwd_addr),
        .fwd_data_i   (fwd_data),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_pc_i      (wr_pc),
        .issue_en_i   (issue_en),
        .issue_addr_i (issue_addr),
        .kill_en_i    (kill_en),
        .kill_addr_i  (kill_addr),
        .issue_ok_o   (issue_ok),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic bit m_hit(int a);
        for (int k = 0; k < 3; k++)
            if (fwd_valid[k] && int'(fwd_addr[k*AWB +: AWB]) == a) return 1'b1;
        return wr_en && (int'(wr_addr) == a);
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        for (int k = 0; k < 3; k++)
            if (fwd_valid[k] && int'(fwd_addr[k*AWB +: AWB]) == a) return fwd_data[k*DW +: DW];
        if (wr_en && int'(wr_addr) == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic bit m_rd_stall(int a);
        return (a != 0) && (m_pend[a] != 0) && !m_hit(a);
    endfunction

    function automatic bit m_stall();
        for (int i = 0; i < 2; i++)
            if (rd_use[i] && m_rd_stall(int'(rd_addr[i*AWB +: AWB]))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_issue_ok();
        return (issue_addr == 0) || (m_pend[issue_addr] != MAXP);
    endfunction

    // Apply one clock edge worth of architectural effects to the model
    function automatic void m_commit();
        bit s;
        int p;
        s = m_stall();
        if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
        for (int r = 1; r < NR; r++) begin
            p = m_pend[r];
            if (issue_en && int'(issue_addr) == r && !s) p = p + 1;
            if (wr_en && int'(wr_addr) == r) p = p - 1;
            if (kill_en && int'(kill_addr) == r) p = p - 1;
            if (p < 0) begin
                p = 0;
                m_err = 1'b1;
            end else if (p > MAXP) begin
                p = MAXP;
                m_err = 1'b1;
            end
            m_pend[r] = p;
        end
    endfunction

    task automatic idle();
        rd_addr = '0; rd_use = '0;
        fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_pc = '0;
        issue_en = 1'b0; issue_addr = '0; kill_en = 1'b0; kill_addr = '0;
    endtask

    task automatic step();
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = {5'd7, 5'd5}; rd_use = 2'b11; issue_addr = 5'd9;
        #1 rst_n = 1'b0;
        #3;
        m_reset();
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (rd_stall !== 2'b00) begin errors++; $display("FAIL reset_rd_stall got %b exp 00", rd_stall); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok got %b exp 1", issue_ok); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; wr_pc = 32'h3000; rd_addr = {5'd0, 5'd5};
        #1;
        checks++; if (rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL wt_r5 got %h exp 00001234", rd_data[31:0]); end
        step();
        idle(); rd_addr = {5'd0, 5'd5};
        #1;
        checks++; if (rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL rd_r5 got %h exp 00001234", rd_data[31:0]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_no_pending_err got %b exp 1", err); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; rd_addr = 10'd0;
        #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL wt_r0 got %h exp 0", rd_data[31:0]); end
        step();
        idle();
        #1;
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL rd_r0 got %h exp 0", rd_data); end
    endtask

    task automatic test_stall_fwd();
        idle(); issue_en = 1'b1; issue_addr = 5'd8;
        #1;
        checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL issue_ok_r8 got %b exp 1", issue_ok); end
        step();
        idle(); rd_addr = {5'd0, 5'd8}; rd_use = 2'b01;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_r8 got %b exp 1", stall); end
        checks++; if (rd_stall !== 2'b01) begin errors++; $display("FAIL rd_stall_r8 got %b exp 01", rd_stall); end
        // an issue while stalled must not be counted
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        idle(); rd_addr = {5'd9, 5'd8}; rd_use = 2'b11;
        #1;
        checks++; if (rd_stall !== 2'b01) begin errors++; $display("FAIL stalled_issue_ignored got %b exp 01", rd_stall); end
        fwd_valid = 3'b010; fwd_addr = {5'd0, 5'd8, 5'd0}; fwd_data = {32'h0, 32'hAA, 32'h0};
        #1;
        checks++; if (rd_data[31:0] !== 32'hAA) begin errors++; $display("FAIL fwd1_data got %h exp 000000aa", rd_data[31:0]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd1_stall got %b exp 0", stall); end
        idle(); wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
        step();
        idle(); rd_addr = {5'd0, 5'd8}; rd_use = 2'b01;
        #1;
        checks++; if ({rd_data[31:0], stall} !== {32'h88, 1'b0}) begin errors++; $display("FAIL r8_retired got %h/%b exp 00000088/0", rd_data[31:0], stall); end
    endtask

    task automatic test_priority();
        idle();
        fwd_valid = 3'b101; fwd_addr = {5'd3, 5'd0, 5'd3}; fwd_data = {32'h22, 32'h0, 32'h11};
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; rd_addr = {5'd3, 5'd3};
        #1;
        checks++; if (rd_data !== {32'h11, 32'h11}) begin errors++; $display("FAIL prio_fwd0 got %h exp 0000001100000011", rd_data); end
        fwd_valid = 3'b100;
        #1;
        checks++; if (rd_data !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_fwd2 got %h exp 0000002200000022", rd_data); end
        fwd_valid = 3'b000;
        #1;
        checks++; if (rd_data !== {32'h33, 32'h33}) begin errors++; $display("FAIL prio_wt got %h exp 0000003300000033", rd_data); end
        step();
        idle(); rd_addr = {5'd3, 5'd3};
        #1;
        checks++; if (rd_data !== {32'h33, 32'h33}) begin errors++; $display("FAIL prio_stored got %h exp 0000003300000033", rd_data); end
    endtask

    task automatic test_overflow();
        idle(); issue_en = 1'b1; issue_addr = 5'd4;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL ovf_issue_ok_%0d got %b exp 1", n, issue_ok); end
            step();
        end
        #1;
        checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL ovf_full got %b exp 0", issue_ok); end
        step();
        idle(); rd_addr = {5'd0, 5'd4}; rd_use = 2'b01; issue_addr = 5'd4;
        #1;
        checks++; if ({stall, issue_ok, err} !== 3'b101) begin errors++; $display("FAIL ovf_hold got %b exp 101", {stall, issue_ok, err}); end
        for (int n = 0; n < 3; n++) begin
            wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'(n);
            step();
            wr_en = 1'b0;
            #1;
            checks++; if (stall !== (n < 2)) begin errors++; $display("FAIL ovf_drain_%0d got %b exp %b", n, stall, (n < 2)); end
        end
    endtask

    task automatic test_async_reset();
        idle(); issue_en = 1'b1; issue_addr = 5'd9;
        step();
        issue_addr = 5'd10;
        step();
        idle(); rd_addr = {5'd10, 5'd5}; rd_use = 2'b11; issue_addr = 5'd10;
        #1;
        checks++; if ({stall, err, rd_data[31:0]} !== {1'b1, 1'b1, 32'h1234}) begin errors++; $display("FAIL pre_reset got %b/%b/%h exp 1/1/00001234", stall, err, rd_data[31:0]); end
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        checks++; if ({stall, rd_stall, err, issue_ok} !== 5'b00001) begin errors++; $display("FAIL async_reset_ctl got %b exp 00001", {stall, rd_stall, err, issue_ok}); end
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL async_reset_data got %h exp 0", rd_data); end
        @(negedge clk) rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_same_cycle();
        idle(); issue_en = 1'b1; issue_addr = 5'd6;
        step();
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        step();
        idle(); rd_addr = {5'd0, 5'd6}; rd_use = 2'b01;
        #1;
        checks++; if ({stall, err} !== 2'b10) begin errors++; $display("FAIL issue_retire_same got %b exp 10", {stall, err}); end
        kill_en = 1'b1; kill_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h67;
        step();
        idle(); rd_addr = {5'd0, 5'd6}; rd_use = 2'b01;
        #1;
        checks++; if ({stall, err, rd_data[31:0]} !== {1'b0, 1'b1, 32'h67}) begin errors++; $display("FAIL kill_wb_unf got %b/%b/%h exp 0/1/00000067", stall, err, rd_data[31:0]); end
    endtask

    task automatic test_random();
        logic [68:0] exp_v;
        logic [68:0] got_v;
        for (int n = 0; n < 600; n++) begin
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd_use     = 2'($urandom);
            fwd_valid  = 3'($urandom) & 3'($urandom);
            fwd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_data   = {$urandom, $urandom, $urandom};
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_addr    = 5'($urandom_range(0, 7));
            wr_data    = $urandom;
            wr_pc      = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = 5'($urandom_range(0, 7));
            kill_en    = ($urandom_range(0, 7) == 0);
            kill_addr  = 5'($urandom_range(0, 7));
            #2;
            exp_v = {m_read(int'(rd_addr[9:5])), m_read(int'(rd_addr[4:0])),
                     m_rd_stall(int'(rd_addr[9:5])), m_rd_stall(int'(rd_addr[4:0])),
                     m_stall(), m_issue_ok(), m_err};
            got_v = {rd_data, rd_stall, stall, issue_ok, err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_%0d got %h exp %h", n, got_v, exp_v);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_write_read();
        test_stall_fwd();
        test_priority();
        test_overflow();
        test_async_reset();
        test_same_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_grf_scoreboard.md
Name: d_grf_scoreboard

Overview:
- Parametrised successor to the decode-stage register file and forwarding logic.
- Provides NRD combinational read ports, one writeback port, FWD_N prioritised forwarding sources and WB write-through.
- A per-register pending-write scoreboard with saturating counters produces a decode stall when a read operand is still in flight and not forwardable.
- Sits in D; consumes E/M/W result buses and the W-stage writeback.

Parameters:
DATA_W, 32, register and data width
NREG, 32, number of architectural registers; register 0 hardwired to zero; AW = clog2(NREG)
NRD, 2, number of read ports
FWD_N, 3, number of forwarding sources; index 0 has the highest priority (youngest stage)
CNT_W, 2, width of the per-register pending counter; max in-flight writes per register = 2^CNT_W-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW]
rd_data  out  NRD*DATA_W  read data after forwarding and bypass
rd_stall  out  NRD  port i operand pending and not forwardable
stall  out  1  OR of rd_stall bits masked by rd_use
rd_use  in  NRD  port i operand actually used by the instruction in D
fwd_valid  in  FWD_N  forwarding source k holds a valid result
fwd_addr  in  FWD_N*AW  destination register of source k
fwd_data  in  FWD_N*DATA_W  result of source k
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback register
wr_data  in  DATA_W  writeback data
wr_pc  in  32  PC of the writing instruction (trace only)
issue_en  in  1  instruction leaving D with a register destination
issue_addr  in  AW  its destination register
kill_en  in  1  squashed in-flight instruction will not write back
kill_addr  in  AW  its destination register
issue_ok  out  1  pending[issue_addr] below max
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers become 0; all pending counters become 0; err becomes 0.
  - Outputs are combinational from the cleared state: rd_data=0, rd_stall=0, stall=0, issue_ok=1.
- Write: at posedge clk, if wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to register 0 are dropped.
- Read data for port i, combinational, first match wins:
  1. rd_addr==0 -> 0.
  2. Lowest k with fwd_valid[k]=1 and fwd_addr[k]==rd_addr -> fwd_data[k].
  3. wr_en=1 and wr_addr==rd_addr -> wr_data (write-through, same cycle).
  4. Otherwise reg[rd_addr].
- rd_stall[i] = (rd_addr!=0) and pending[rd_addr]!=0 and no source in step 2 or 3 matches.
- stall = OR over i of (rd_stall[i] and rd_use[i]).
- Scoreboard, per register r (r!=0), updated at posedge:
  - inc = issue_en and issue_addr==r and not stall.
  - dec = (wr_en and wr_addr==r) + (kill_en and kill_addr==r); dec may be 0, 1 or 2.
  - pending[r] <= pending[r] + inc - dec.
  - Same-cycle issue and retire of one register leaves the count unchanged.
  - An issue while stall=1 is ignored.
- Boundary rules:
  - Underflow (dec exceeds pending+inc): counter clamps to 0; err <= 1.
  - Overflow (inc with pending at max and dec=0): counter holds at max; err <= 1.
  - err clears only on reset.
  - Register 0 is never pending; issue, kill and write to it are ignored with no error.
- issue_ok = (issue_addr==0) or pending[issue_addr] != max; combinational.
- Latency: reads, stall and issue_ok are zero-cycle; state updates are one cycle.

Optional Feature:
GRF_TRACE_EN
- Defined: on every accepted write (wr_en=1, wr_addr!=0), simulation prints "@<wr_pc hex>: $<wr_addr dec> <= <wr_data hex>" with the time stamp. On each err rising edge it prints the error kind (overflow/underflow) and the register number. Simulation only; no hardware impact.
- Undefined: no display statements; RTL is identical otherwise.

Decomposition:
- Shared package: AW derivation function (clog2), register-0 constant, err-kind encodings (ERR_OVF, ERR_UNF) used by the trace.
- One sub-module, d_fwd_select: one read port's priority forwarding mux and match logic, producing data and a hit flag; instantiated NRD times with a generate loop.
- Register array and scoreboard counters stay in the top module.

Test Plan:
- Reset, then write $5=0x1234 at PC 0x3000 -> next cycle rd_addr0=5 returns 0x1234; reading $0 returns 0 after a write of 0xFFFF to $0.
- issue $8; next cycle rd_addr0=8, rd_use0=1, no forwarding -> stall=1; assert fwd_valid[1] with addr 8, data 0xAA -> rd_data0=0xAA, stall=0.
- fwd sources 0 and 2 both target $3 (0x11, 0x22) while wr_en also writes $3=0x33 -> rd_data returns 0x11; drop fwd sources -> 0x33 same cycle.
- With CNT_W=2, issue $4 three times -> issue_ok=0; a fourth issue -> err=1 and count holds at 3; three writebacks -> pending=0, stall clears.
- Issue and writeback of $6 in the same cycle with pending=1 -> stays 1; kill plus writeback of $6 with pending=1 -> 0, err=1.
- Drive reset low asynchronously mid-stream with pending counts nonzero -> all counts 0, stall=0, err=0 immediately, before the next clock edge.
